// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared seven-segment encodings, frame type and helpers
// Contents: active-low {g..a} hex codes, blank / anode-off codes,
//           frame_t (latched display content), anode_on() digit-select helper.
package seven_seg_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] ANODE_OFF = 8'hFF;
   localparam logic [6:0] SEG_OFF   = 7'h7F;

   localparam logic [6:0] SEG_HEX_0 = 7'h40;
   localparam logic [6:0] SEG_HEX_1 = 7'h79;
   localparam logic [6:0] SEG_HEX_2 = 7'h24;
   localparam logic [6:0] SEG_HEX_3 = 7'h30;
   localparam logic [6:0] SEG_HEX_4 = 7'h19;
   localparam logic [6:0] SEG_HEX_5 = 7'h12;
   localparam logic [6:0] SEG_HEX_6 = 7'h02;
   localparam logic [6:0] SEG_HEX_7 = 7'h78;
   localparam logic [6:0] SEG_HEX_8 = 7'h00;
   localparam logic [6:0] SEG_HEX_9 = 7'h10;
   localparam logic [6:0] SEG_HEX_A = 7'h08;
   localparam logic [6:0] SEG_HEX_B = 7'h03;
   localparam logic [6:0] SEG_HEX_C = 7'h46;
   localparam logic [6:0] SEG_HEX_D = 7'h21;
   localparam logic [6:0] SEG_HEX_E = 7'h06;
   localparam logic [6:0] SEG_HEX_F = 7'h0E;

   typedef struct packed {
      logic        blank_lz;
      logic [7:0]  point;
      logic [31:0] num;
   } frame_t;

   localparam frame_t FRAME_RESET = '0;

   // Active-low one-cold enable for digit idx.
   function automatic logic [7:0] anode_on(input logic [2:0] idx);
      return ~(8'h01 << idx);
   endfunction

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational hex nibble to active-low {g..a} segment decoder
// Ports: hex_i [3:0] nibble in; seg_o [6:0] active-low segments {g,f,e,d,c,b,a}.
module hex_to_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_OFF;
      case (hex_i)
         4'h0: seg_o = SEG_HEX_0;
         4'h1: seg_o = SEG_HEX_1;
         4'h2: seg_o = SEG_HEX_2;
         4'h3: seg_o = SEG_HEX_3;
         4'h4: seg_o = SEG_HEX_4;
         4'h5: seg_o = SEG_HEX_5;
         4'h6: seg_o = SEG_HEX_6;
         4'h7: seg_o = SEG_HEX_7;
         4'h8: seg_o = SEG_HEX_8;
         4'h9: seg_o = SEG_HEX_9;
         4'hA: seg_o = SEG_HEX_A;
         4'hB: seg_o = SEG_HEX_B;
         4'hC: seg_o = SEG_HEX_C;
         4'hD: seg_o = SEG_HEX_D;
         4'hE: seg_o = SEG_HEX_E;
         4'hF: seg_o = SEG_HEX_F;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - 8-digit multiplexed seven-segment scan driver
// Ports: clk; reset (async, active-low); disp_num [31:0] eight hex nibbles,
//        digit 0 rightmost; point [7:0] decimal points; blank_lz leading-zero
//        blanking; anode [7:0] active-low digit enables; segment [7:0]
//        active-low {dp,g..a}; frame_done one-cycle pulse at end of digit 7 slot.
module seven_seg_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int DIV_BITS     = 17,
   parameter int BLANK_CYCLES = 64
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] disp_num,
   input  logic [7:0]  point,
   input  logic        blank_lz,
   output logic [7:0]  anode,
   output logic [7:0]  segment,
   output logic        frame_done
);

   localparam logic [DIV_BITS-1:0] BLANK_CNT = DIV_BITS'(BLANK_CYCLES);

   logic [DIV_BITS-1:0] cnt_q, cnt_d;
   logic [2:0]          idx_q, idx_d;
   frame_t              frame_q, frame_d;
   logic                load_pending_q, load_pending_d;
   logic [7:0]          anode_q, anode_d;
   logic [7:0]          segment_q, segment_d;

   logic                tick;
   logic                wrap;
   logic [3:0]          nib;
   logic [6:0]          seg7;
   logic [7:0]          upper_zero;
   logic                blank_digit;

   assign tick = (cnt_q == '1);
   assign wrap = tick && (idx_q == 3'd7);

   // Frame content only changes at a frame boundary so a digit sequence is never torn.
   always_comb begin
      cnt_d          = cnt_q + 1'b1;
      idx_d          = tick ? idx_q + 3'd1 : idx_q;
      load_pending_d = 1'b0;
      frame_d        = frame_q;
      if (load_pending_q || wrap) begin
         frame_d.num      = disp_num;
         frame_d.point    = point;
         frame_d.blank_lz = blank_lz;
      end
   end

   assign nib = frame_q.num[{idx_q, 2'b00} +: 4];

   hex_to_seg u_hex_to_seg (
      .hex_i (nib),
      .seg_o (seg7)
   );

   // upper_zero[k] is set when nibbles k..7 are all zero.
   always_comb begin
      logic acc;
      acc        = 1'b1;
      upper_zero = '0;
      for (int k = 7; k >= 0; k--) begin
         acc           = acc && (frame_q.num[4*k +: 4] == 4'h0);
         upper_zero[k] = acc;
      end
   end

   // Digit 0 always shows, so a value of zero still displays "0".
   assign blank_digit = frame_q.blank_lz && (idx_q != 3'd0) && upper_zero[idx_q];

   always_comb begin
      segment_d = {~frame_q.point[idx_q], blank_digit ? SEG_OFF : seg7};
      anode_d   = (cnt_q < BLANK_CNT) ? ANODE_OFF : anode_on(idx_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q          <= '0;
         idx_q          <= '0;
         frame_q        <= FRAME_RESET;
         load_pending_q <= 1'b1;
         anode_q        <= ANODE_OFF;
         segment_q      <= SEG_BLANK;
      end else begin
         cnt_q          <= cnt_d;
         idx_q          <= idx_d;
         frame_q        <= frame_d;
         load_pending_q <= load_pending_d;
         anode_q        <= anode_d;
         segment_q      <= segment_d;
      end
   end

   assign anode      = anode_q;
   assign segment    = segment_q;
   assign frame_done = wrap;

endmodule
